ex_stage: RTL and testbench
===========================

# ex_stage

Execute stage of the five-stage pipeline. Consumes the operands, opcode, destination address and write enable registered by the ID/EX pipeline register and produces the write-back triple for the EX/MEM register. It owns the HI/LO registers, a single-cycle 32×32 multiplier and an iterative radix-2 divider. While a divide is in flight it stalls the upstream stages.

## Interface
Parameters:
- DIV_CYCLES, 32: divider iteration count; must equal the operand width.

Ports:
- clk  in  1  pipeline clock; all state updates on the rising edge.
- rst  in  1  asynchronous, active-low reset.
- input_1  in  32  operand A (rs value, or zero-extended shamt for shifts, per decode).
- input_2  in  32  operand B (rt value or extended immediate).
- inst_op_i  in  32  opcode; only bits [7:0] are decoded; other bits are ignored.
- write_enable_i  in  1  decode's register write request.
- write_addr_i  in  5  destination register.
- flush  in  1  aborts any in-flight divide; HI/LO are left unchanged.
- write_addr_o  out  5  passes write_addr_i through.
- write_data_o  out  32  result.
- write_enable_o  out  1  gated write enable.
- stall_req  out  1  high means the ID/EX stage must hold its outputs.
- hi_o, lo_o  out  32  current HI/LO contents.

## Operation
- Opcode map, inst_op_i[7:0]:
  - 0 NOP; 1 OR; 2 AND; 3 XOR; 4 NOR; 5 ADDU; 6 SUBU.
  - 7 SLT (signed); 8 SLTU.
  - 9 SLL; 10 SRL; 11 SRA: shift input_2 by input_1[4:0].
  - 12 MULT; 13 MULTU; 14 DIV; 15 DIVU.
  - 16 MFHI; 17 MFLO; 18 MTHI (input_1); 19 MTLO (input_1).
  - Any other value behaves as NOP.
- Arithmetic:
  - All ALU ops are 32-bit with wrap-around; no overflow trap.
  - SLT/SLTU produce 0x00000001 or 0x00000000.
- Write enable:
  - write_enable_o = write_enable_i for ops 1–11, 16 and 17.
  - write_enable_o = 0 for NOP, ops 12–15, 18 and 19.
  - When write_enable_o = 0, write_data_o = 0.
- MULT/MULTU: the 64-bit product is computed combinationally. {HI,LO} are written at the end of the same cycle. No stall.
- Divider state machine, states IDLE, RUN, DONE:
  - IDLE, op 14/15, divisor ≠ 0: stall_req = 1. Latch magnitudes and result signs (DIV only). Clear the counter. Go to RUN.
  - IDLE, op 14/15, divisor = 0: stall_req = 1. Go to DONE with quotient = 0xFFFFFFFF and remainder = dividend.
  - RUN: one restoring shift/subtract step per cycle; stall_req = 1. After step DIV_CYCLES−1, go to DONE.
  - DONE: stall_req = 0. Apply signs: quotient negated if the operand signs differ; remainder takes the dividend's sign. Write LO = quotient and HI = remainder at the end of the cycle. Go to IDLE.
- Operands are latched at entry to RUN. Upstream holding its inputs is required for correct write-back fields, not for the division result.
- flush = 1 in any state: next state IDLE, stall_req deasserts combinationally, HI/LO unchanged. flush has priority over a DONE write.
- If both stall_req = 1 and a MULT/MT* arrive, that cannot occur: the divider stalls the pipe, so no other op is presented.

## Timing
- ALU ops, MF*, and write_addr_o / write_data_o / write_enable_o are combinational from the inputs (zero latency).
- HI/LO update one edge after a MULT*/MT* cycle, so an MFHI in the very next cycle sees the new value.
- DIV issued in cycle n (divisor ≠ 0):
  - stall_req is high in cycles n through n+32.
  - The state is DONE in cycle n+33, with stall_req low.
  - HI/LO are valid in cycle n+34.
- Divide by zero: stall_req is high in cycle n only, DONE in cycle n+1, HI/LO valid in cycle n+2.
- Reset asserted (rst = 0), including mid-divide:
  - The state goes to IDLE immediately; counter, HI and LO clear to 0.
  - stall_req = 0, write_enable_o = 0, write_data_o = 0, write_addr_o = 0; all outputs held while reset is low.
- Release: the first rising edge after rst goes high is a normal cycle.

## Test plan
- ADDU with input_1 = 0xFFFFFFFF, input_2 = 2, write_enable_i = 1, write_addr_i = 5 -> write_data_o = 0x00000001, write_enable_o = 1, write_addr_o = 5, same cycle.
- SLT with input_1 = 0x80000000, input_2 = 1 -> write_data_o = 1. SLTU with the same operands -> write_data_o = 0.
- MULT with input_1 = 0xFFFFFFFE (−2), input_2 = 3, next cycle MFHI then MFLO -> write_data_o = 0xFFFFFFFF, then 0xFFFFFFFA. stall_req stays 0 throughout.
- DIV with input_1 = −7, input_2 = 2 in cycle n -> stall_req high for exactly 33 cycles; then LO = 0xFFFFFFFD, HI = 0xFFFFFFFF. write_enable_o = 0 throughout.
- DIVU with input_2 = 0, input_1 = 0x1234 -> one stall cycle; then LO = 0xFFFFFFFF, HI = 0x00001234.
- Preload HI = 0xAAAA with MTHI, start DIVU 100/7, then pulse flush in RUN cycle 10 -> stall_req drops that cycle and HI stays 0xAAAA. Repeat with rst = 0 mid-RUN -> all outputs, HI and LO read 0 immediately.

Source files
------------

// File: rtl/ex_stage.sv
// Execute stage: ALU, HI/LO registers, a single-cycle multiplier and an
// iterative restoring divider that stalls the upstream stages while busy.
module ex_stage #(
    parameter int DIV_CYCLES = 32
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] input_1,
    input  logic [31:0] input_2,
    input  logic [31:0] inst_op_i,
    input  logic        write_enable_i,
    input  logic [4:0]  write_addr_i,
    input  logic        flush,
    output logic [4:0]  write_addr_o,
    output logic [31:0] write_data_o,
    output logic        write_enable_o,
    output logic        stall_req,
    output logic [31:0] hi_o,
    output logic [31:0] lo_o
);

    localparam int CNT_W = $clog2(DIV_CYCLES);

    localparam logic [7:0] OP_OR    = 8'd1;
    localparam logic [7:0] OP_AND   = 8'd2;
    localparam logic [7:0] OP_XOR   = 8'd3;
    localparam logic [7:0] OP_NOR   = 8'd4;
    localparam logic [7:0] OP_ADDU  = 8'd5;
    localparam logic [7:0] OP_SUBU  = 8'd6;
    localparam logic [7:0] OP_SLT   = 8'd7;
    localparam logic [7:0] OP_SLTU  = 8'd8;
    localparam logic [7:0] OP_SLL   = 8'd9;
    localparam logic [7:0] OP_SRL   = 8'd10;
    localparam logic [7:0] OP_SRA   = 8'd11;
    localparam logic [7:0] OP_MULT  = 8'd12;
    localparam logic [7:0] OP_MULTU = 8'd13;
    localparam logic [7:0] OP_DIV   = 8'd14;
    localparam logic [7:0] OP_DIVU  = 8'd15;
    localparam logic [7:0] OP_MFHI  = 8'd16;
    localparam logic [7:0] OP_MFLO  = 8'd17;
    localparam logic [7:0] OP_MTHI  = 8'd18;
    localparam logic [7:0] OP_MTLO  = 8'd19;

    typedef enum logic [1:0] {IDLE, RUN, DONE} div_state_e;

    div_state_e       state;
    logic [CNT_W-1:0] cnt;
    logic [31:0]      hi, lo;
    logic [31:0]      div_quo, div_rem, div_den;
    logic             neg_q, neg_r;

    logic [7:0]  op;
    logic [31:0] alu_res;
    logic        wr_ok;
    logic        is_div, div_signed, is_mul;
    logic [31:0] a_mag, b_mag;
    logic [63:0] mul_a, mul_b, product;
    logic [32:0] trial;
    logic        unused_op_bits;

    assign op             = inst_op_i[7:0];
    assign unused_op_bits = ^inst_op_i[31:8];

    // NOTE: every variable written in always_comb gets a default first, so
    // unlisted opcodes cannot leave a path unassigned and infer a latch.
    always_comb begin
        alu_res = '0;
        wr_ok   = 1'b1;
        case (op)
            OP_OR:   alu_res = input_1 | input_2;
            OP_AND:  alu_res = input_1 & input_2;
            OP_XOR:  alu_res = input_1 ^ input_2;
            OP_NOR:  alu_res = ~(input_1 | input_2);
            OP_ADDU: alu_res = input_1 + input_2;
            OP_SUBU: alu_res = input_1 - input_2;
            OP_SLT:  alu_res = {31'b0, $signed(input_1) < $signed(input_2)};
            OP_SLTU: alu_res = {31'b0, input_1 < input_2};
            OP_SLL:  alu_res = input_2 << input_1[4:0];
            OP_SRL:  alu_res = input_2 >> input_1[4:0];
            OP_SRA:  alu_res = $signed(input_2) >>> input_1[4:0];
            OP_MFHI: alu_res = hi;
            OP_MFLO: alu_res = lo;
            default: wr_ok   = 1'b0;
        endcase
    end

    assign is_div     = (op == OP_DIV) || (op == OP_DIVU);
    assign div_signed = (op == OP_DIV);
    assign is_mul     = (op == OP_MULT) || (op == OP_MULTU);
    assign a_mag      = (div_signed && input_1[31]) ? -input_1 : input_1;
    assign b_mag      = (div_signed && input_2[31]) ? -input_2 : input_2;

    // Low 64 bits of the extended product are correct for both signednesses.
    assign mul_a   = (op == OP_MULT) ? {{32{input_1[31]}}, input_1} : {32'b0, input_1};
    assign mul_b   = (op == OP_MULT) ? {{32{input_2[31]}}, input_2} : {32'b0, input_2};
    assign product = mul_a * mul_b;

    // Restoring step: borrow out of the trial subtract means the bit is 0.
    assign trial = {div_rem, div_quo[31]} - {1'b0, div_den};

    // NOTE: sequential state uses non-blocking assignments only, so every
    // register samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state   <= IDLE;
            cnt     <= '0;
            hi      <= '0;
            lo      <= '0;
            div_quo <= '0;
            div_rem <= '0;
            div_den <= '0;
            neg_q   <= 1'b0;
            neg_r   <= 1'b0;
        end else if (flush) begin
            state <= IDLE;
        end else begin
            case (state)
                IDLE: begin
                    if (is_div) begin
                        if (input_2 != '0) begin
                            div_quo <= a_mag;
                            div_rem <= '0;
                            div_den <= b_mag;
                            neg_q   <= div_signed && (input_1[31] ^ input_2[31]);
                            neg_r   <= div_signed && input_1[31];
                            cnt     <= '0;
                            state   <= RUN;
                        end else begin
                            div_quo <= '1;
                            div_rem <= input_1;
                            neg_q   <= 1'b0;
                            neg_r   <= 1'b0;
                            state   <= DONE;
                        end
                    end else if (is_mul) begin
                        {hi, lo} <= product;
                    end else if (op == OP_MTHI) begin
                        hi <= input_1;
                    end else if (op == OP_MTLO) begin
                        lo <= input_1;
                    end
                end
                RUN: begin
                    div_quo <= {div_quo[30:0], ~trial[32]};
                    div_rem <= trial[32] ? {div_rem[30:0], div_quo[31]} : trial[31:0];
                    cnt     <= cnt + 1'b1;
                    if (cnt == CNT_W'(DIV_CYCLES - 1))
                        state <= DONE;
                end
                DONE: begin
                    lo    <= neg_q ? -div_quo : div_quo;
                    hi    <= neg_r ? -div_rem : div_rem;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign write_addr_o   = rst ? write_addr_i : '0;
    assign write_enable_o = rst && wr_ok && write_enable_i;
    assign write_data_o   = write_enable_o ? alu_res : '0;
    assign stall_req      = rst && !flush && (((state == IDLE) && is_div) || (state == RUN));
    assign hi_o           = hi;
    assign lo_o           = lo;

endmodule

// File: tb/tb_ex_stage.sv
// Randomized bench for ex_stage, checked against an arithmetic reference
// model of the ALU, HI/LO, multiply and divide behaviour.
module tb_ex_stage;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] input_1, input_2, inst_op_i;
    logic        write_enable_i;
    logic [4:0]  write_addr_i;
    logic        flush;
    logic [4:0]  write_addr_o;
    logic [31:0] write_data_o;
    logic        write_enable_o;
    logic        stall_req;
    logic [31:0] hi_o, lo_o;

    int checks   = 0;
    int failures = 0;

    logic [31:0] m_hi = '0;
    logic [31:0] m_lo = '0;

    ex_stage #(.DIV_CYCLES(32)) dut (
        .clk            (clk),
        .rst            (rst),
        .input_1        (input_1),
        .input_2        (input_2),
        .inst_op_i      (inst_op_i),
        .write_enable_i (write_enable_i),
        .write_addr_i   (write_addr_i),
        .flush          (flush),
        .write_addr_o   (write_addr_o),
        .write_data_o   (write_data_o),
        .write_enable_o (write_enable_o),
        .stall_req      (stall_req),
        .hi_o           (hi_o),
        .lo_o           (lo_o)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic drive(input logic [31:0] op, input logic [31:0] a, input logic [31:0] b,
                         input logic we, input logic [4:0] addr);
        inst_op_i      = op;
        input_1        = a;
        input_2        = b;
        write_enable_i = we;
        write_addr_i   = addr;
    endtask

    // Reference: result and write enable of one combinational op.
    task automatic model_alu(input logic [31:0] op_full, input logic [31:0] a, input logic [31:0] b,
                             input logic we_i, output logic [31:0] data, output logic we);
        int          op;
        int          sh;
        logic [31:0] r;
        op = int'(op_full[7:0]);
        sh = int'(a[4:0]);
        r  = 0;
        case (op)
            1:  r = a | b;
            2:  r = a & b;
            3:  r = a ^ b;
            4:  r = ~(a | b);
            5:  r = a + b;
            6:  r = a - b;
            7:  r = (int'(a) < int'(b)) ? 32'd1 : 32'd0;
            8:  r = ({32'b0, a} < {32'b0, b}) ? 32'd1 : 32'd0;
            9:  r = b << sh;
            10: r = b >> sh;
            11: r = 32'(int'(b) >>> sh);
            16: r = m_hi;
            17: r = m_lo;
            default: r = 0;
        endcase
        we   = we_i && ((op >= 1 && op <= 11) || op == 16 || op == 17);
        data = we ? r : 32'd0;
    endtask

    // Reference: HI/LO effect of a single-cycle op at the end of its cycle.
    task automatic model_hilo(input logic [31:0] op_full, input logic [31:0] a, input logic [31:0] b);
        logic [63:0] p;
        case (op_full[7:0])
            8'd12: begin p = longint'($signed(a)) * longint'($signed(b)); {m_hi, m_lo} = p; end
            8'd13: begin p = {32'b0, a} * {32'b0, b}; {m_hi, m_lo} = p; end
            8'd18: m_hi = a;
            8'd19: m_lo = a;
            default: ;
        endcase
    endtask

    // One non-divide op: inputs set after the edge, outputs checked at negedge.
    task automatic alu_cycle(input logic [31:0] op, input logic [31:0] a, input logic [31:0] b,
                             input logic we, input logic [4:0] addr);
        logic [31:0] exp_d;
        logic        exp_we;
        drive(op, a, b, we, addr);
        model_alu(op, a, b, we, exp_d, exp_we);
        @(negedge clk);
        check("data", write_data_o, exp_d);
        check("we", 32'(write_enable_o), 32'(exp_we));
        check("addr", 32'(write_addr_o), 32'(addr));
        check("stall", 32'(stall_req), 32'd0);
        check("hi", hi_o, m_hi);
        check("lo", lo_o, m_lo);
        @(posedge clk);
        model_hilo(op, a, b);
        #1;
    endtask

    task automatic run_div(input logic is_signed, input logic [31:0] a, input logic [31:0] b);
        longint sa, sb, q, r;
        int     n;
        int     exp_n;
        drive(is_signed ? 32'd14 : 32'd15, a, b, 1'b1, 5'($urandom_range(1, 31)));
        n = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (!stall_req) break;
            check("div_we", 32'(write_enable_o), 32'd0);
            n++;
        end
        exp_n = (b == 0) ? 1 : 33;
        check("div_stall_cycles", n, exp_n);
        check("div_done_we", 32'(write_enable_o), 32'd0);
        if (b == 0) begin
            q = 64'hFFFF_FFFF;
            r = longint'({32'b0, a});
        end else begin
            sa = is_signed ? longint'($signed(a)) : longint'({32'b0, a});
            sb = is_signed ? longint'($signed(b)) : longint'({32'b0, b});
            q  = sa / sb;
            r  = sa % sb;
        end
        @(posedge clk);
        #1;
        drive(32'd0, 32'd0, 32'd0, 1'b0, 5'd0);
        m_lo = q[31:0];
        m_hi = r[31:0];
        @(negedge clk);
        check("div_lo", lo_o, m_lo);
        check("div_hi", hi_o, m_hi);
        check("div_idle_stall", 32'(stall_req), 32'd0);
        @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] pick_operand();
        logic [31:0] corner [4];
        corner[0] = 32'h0;
        corner[1] = 32'hFFFF_FFFF;
        corner[2] = 32'h8000_0000;
        corner[3] = 32'h7FFF_FFFF;
        if ($urandom_range(0, 3) == 0) return corner[$urandom_range(0, 3)];
        return $urandom();
    endfunction

    initial begin
        logic [31:0] rnd, op, a, b;
        int          sel;

        // Reset asserted with live inputs: every output forced to zero.
        rst   = 1'b0;
        flush = 1'b0;
        drive(32'd5, 32'h11, 32'h22, 1'b1, 5'd7);
        @(negedge clk);
        check("rst_data", write_data_o, 32'd0);
        check("rst_we", 32'(write_enable_o), 32'd0);
        check("rst_addr", 32'(write_addr_o), 32'd0);
        check("rst_stall", 32'(stall_req), 32'd0);
        check("rst_hi", hi_o, 32'd0);
        check("rst_lo", lo_o, 32'd0);
        #1 rst = 1'b1;
        @(posedge clk);
        #1;

        alu_cycle(32'd5, 32'hFFFF_FFFF, 32'd2, 1'b1, 5'd5);
        alu_cycle(32'd7, 32'h8000_0000, 32'd1, 1'b1, 5'd3);
        alu_cycle(32'd8, 32'h8000_0000, 32'd1, 1'b1, 5'd3);
        alu_cycle(32'd12, 32'hFFFF_FFFE, 32'd3, 1'b1, 5'd4);
        alu_cycle(32'd16, 32'd0, 32'd0, 1'b1, 5'd8);
        alu_cycle(32'd17, 32'd0, 32'd0, 1'b1, 5'd9);
        check("mult_hi_const", m_hi, 32'hFFFF_FFFF);
        check("mult_lo_const", m_lo, 32'hFFFF_FFFA);
        alu_cycle(32'd11, 32'd31, 32'h8000_0000, 1'b1, 5'd1);
        alu_cycle(32'd9, 32'd0, 32'hDEAD_BEEF, 1'b1, 5'd2);
        alu_cycle(32'hFF00_0001, 32'hF0, 32'h0F, 1'b1, 5'd6);
        alu_cycle(32'd99, 32'h1, 32'h2, 1'b1, 5'd6);

        run_div(1'b1, 32'hFFFF_FFF9, 32'd2);
        check("div_neg7_lo", lo_o, 32'hFFFF_FFFD);
        check("div_neg7_hi", hi_o, 32'hFFFF_FFFF);
        run_div(1'b0, 32'h1234, 32'd0);
        check("divz_lo", lo_o, 32'hFFFF_FFFF);
        check("divz_hi", hi_o, 32'h0000_1234);
        run_div(1'b1, 32'h8000_0000, 32'hFFFF_FFFF);
        run_div(1'b0, 32'hFFFF_FFFF, 32'd1);

        for (int i = 0; i < 8; i++) begin
            a = pick_operand();
            b = pick_operand();
            if (b == 0) b = 32'd13;
            run_div(i[0], a, b);
        end

        // Flush in the 10th RUN cycle: divide abandoned, HI untouched.
        alu_cycle(32'd18, 32'h0000_AAAA, 32'd0, 1'b0, 5'd0);
        drive(32'd15, 32'd100, 32'd7, 1'b0, 5'd0);
        repeat (10) @(posedge clk);
        #1;
        check("pre_flush_stall", 32'(stall_req), 32'd1);
        flush = 1'b1;
        #1;
        check("flush_stall", 32'(stall_req), 32'd0);
        @(posedge clk);
        #1;
        flush = 1'b0;
        alu_cycle(32'd16, 32'd0, 32'd0, 1'b1, 5'd10);
        check("flush_hi_const", m_hi, 32'h0000_AAAA);
        alu_cycle(32'd0, 32'd0, 32'd0, 1'b0, 5'd0);

        // Reset in the middle of a divide.
        alu_cycle(32'd19, 32'h5555_0000, 32'd0, 1'b0, 5'd0);
        drive(32'd15, 32'd1000, 32'd3, 1'b1, 5'd12);
        repeat (5) @(posedge clk);
        #1;
        check("pre_rst_stall", 32'(stall_req), 32'd1);
        rst = 1'b0;
        #1;
        check("midrst_stall", 32'(stall_req), 32'd0);
        check("midrst_we", 32'(write_enable_o), 32'd0);
        check("midrst_data", write_data_o, 32'd0);
        check("midrst_addr", 32'(write_addr_o), 32'd0);
        check("midrst_hi", hi_o, 32'd0);
        check("midrst_lo", lo_o, 32'd0);
        m_hi = '0;
        m_lo = '0;
        @(negedge clk);
        drive(32'd0, 32'd0, 32'd0, 1'b0, 5'd0);
        #1 rst = 1'b1;
        @(posedge clk);
        #1;
        alu_cycle(32'd17, 32'd0, 32'd0, 1'b1, 5'd11);

        // Random single-cycle ops, including MULT*/MT* and unknown opcodes.
        for (int i = 0; i < 300; i++) begin
            rnd = $urandom();
            sel = int'($urandom_range(0, 21));
            if (sel == 14 || sel == 15) sel = sel + 2;
            if (sel >= 20) sel = int'($urandom_range(20, 255));
            op = {rnd[31:8], 8'(sel)};
            if (rnd[0]) op[31:8] = '0;
            alu_cycle(op, pick_operand(), pick_operand(), rnd[1] | rnd[2], 5'(rnd[7:3]));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
